serial_add_ovf_nch: RTL and testbench
=====================================

// Module: serial_add_ovf_nch
// PURPOSE
//   NCH-lane serial adder with per-lane overflow detection; parametrised successor of the b01 serial-flow FSM.
//   Each lane adds two LSB-first bit streams (line_a, line_b) over WORD_W-bit words.
//   It emits the registered sum bit per cycle and a per-lane overflow flag at word end.
//   Lanes run in lock-step under one shared bit counter and FSM.
// PARAMETERS
//   NCH      2   number of independent adder lanes (>=1)
//   WORD_W   8   bits per word (>=1); CNT_W = max(1,$clog2(WORD_W))
//   SIGNED   0   0: overflow = carry out of MSB; 1: overflow = carry-into-MSB ^ carry-out-of-MSB
// PORTS
//   clock       in   1       rising-edge clock, single domain
//   reset_n     in   1       asynchronous active-low reset
//   clear       in   1       synchronous abort: drop partial word, zero carries/counter
//   in_valid    in   1       line_a/line_b carry a valid bit this cycle
//   line_a      in   NCH     operand A bit per lane, LSB first
//   line_b      in   NCH     operand B bit per lane, LSB first
//   outp        out  NCH     registered sum bit per lane
//   outp_valid  out  1       outp holds a new sum bit (1-cycle pulse per accepted bit)
//   word_done   out  1       pulses with outp_valid on the last (MSB) sum bit of a word
//   overflw     out  NCH     per-lane overflow of the last completed word; held until next word_done
//   bit_idx     out  CNT_W   index of the next bit to be accepted (0..WORD_W-1)
// BEHAVIOUR
//   Reset (async, reset_n=0): outp=0, outp_valid=0, word_done=0, overflw=0, bit_idx=0,
//     carries=0, FSM=IDLE. Outputs stay at these values until the first accepted bit.
//   FSM: IDLE (bit_idx=0, no word open) / RUN (word in progress).
//     IDLE + in_valid: accept bit 0 -> RUN. If WORD_W==1, the word completes immediately and the FSM stays IDLE.
//     RUN + in_valid at bit_idx==WORD_W-1: accept MSB, complete the word -> IDLE.
//     RUN + in_valid at any other index: accept, bit_idx++.
//     in_valid=0: hold all state; outp_valid=0; outp keeps its last value.
//   Per accepted bit, per lane i, with c=carry[i]:
//     outp[i] <= a^b^c; carry[i] <= maj(a,b,c). Latency: 1 clock, input edge to outp_valid.
//   Word completion (MSB accepted):
//     word_done=1 and outp_valid=1 in the following cycle.
//     overflw[i] <= SIGNED ? (c ^ maj(a,b,c)) : maj(a,b,c); updated in the same cycle.
//     Carries and bit_idx reset to 0; the next bit starts a new word without a gap.
//   Back-to-back: in_valid held high streams words continuously, and word_done fires every WORD_W cycles.
//   clear=1 (any state): carries=0, bit_idx=0, FSM=IDLE, outp_valid=0, word_done=0.
//     clear beats a simultaneous in_valid; that bit is discarded.
//     overflw and outp retain their values.
//   Async reset mid-word: the partial word is lost with no word_done; the next word starts at bit 0.
//   bit_idx wraps WORD_W-1 -> 0 only on word completion and never exceeds WORD_W-1.
//   All lanes share bit_idx/outp_valid/word_done; lanes differ only in data, carry and overflw.
// TESTING
//   Setup: WORD_W=8, NCH=2, SIGNED=0.
//     lane0 0x7F+0x01, lane1 0xFF+0x01, in_valid=1 for 8 cycles.
//     -> outp lane0 serialises 0x80, lane1 0x00; word_done on 8th outp_valid; overflw=2'b10.
//   Same stimulus with SIGNED=1 -> overflw=2'b01 (0x7F+1 signed ovf; -1+1 none).
//   Stall: lane0 0x55+0x2A with in_valid low for 3 cycles after bits 2 and 5.
//     -> sum 0x7F, exactly 8 outp_valid pulses, word_done only on the last; overflw[0]=0.
//   clear asserted with in_valid at bit_idx=3, then fresh 0xFF+0xFF.
//     -> the clear-cycle bit is dropped; next word sum 0xFE; overflw[0]=1 (unsigned); bit_idx back to 0.
//   reset_n pulsed low mid-word at bit_idx=5.
//     -> all outputs 0 immediately; no word_done; next 0x01+0x01 gives 0x02, ovf 0.
//   WORD_W=1, SIGNED=0: a=b=1 -> outp=0, word_done every accepted cycle, overflw=1; a=1,b=0 -> overflw=0.

Source files
------------

// File: rtl/serial_add_ovf_nch.sv
// NCH-lane LSB-first serial adder with per-lane word overflow.
// All lanes share one bit counter and one IDLE/RUN FSM; each lane keeps its
// own carry, registered sum bit and overflow flag.
module serial_add_ovf_nch #(
  parameter int unsigned NCH    = 2,
  parameter int unsigned WORD_W = 8,
  parameter int unsigned SIGNED = 0,
  localparam int unsigned CNT_W = (WORD_W > 1) ? $clog2(WORD_W) : 1
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             clear,
  input  logic             in_valid,
  input  logic [NCH-1:0]   line_a,
  input  logic [NCH-1:0]   line_b,
  output logic [NCH-1:0]   outp,
  output logic             outp_valid,
  output logic             word_done,
  output logic [NCH-1:0]   overflw,
  output logic [CNT_W-1:0] bit_idx
);

  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(WORD_W - 1);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [NCH-1:0]   carry_q, carry_d;
  logic [NCH-1:0]   outp_q, outp_d;
  logic [NCH-1:0]   ovf_q, ovf_d;
  logic             vld_q, vld_d;
  logic             done_q, done_d;

  logic [NCH-1:0]   sum_bits;
  logic [NCH-1:0]   carry_out;
  logic [NCH-1:0]   ovf_word;
  logic             last_bit;

  // Per-lane full-adder slice and word-end overflow candidate.
  always_comb begin
    sum_bits  = line_a ^ line_b ^ carry_q;
    carry_out = (line_a & line_b) | (line_a & carry_q) | (line_b & carry_q);
    if (SIGNED != 0) begin
      ovf_word = carry_q ^ carry_out;
    end else begin
      ovf_word = carry_out;
    end
    last_bit = (cnt_q == LAST_IDX);
  end

  // Next-state logic: clear wins over in_valid; a stalled cycle holds everything
  // except the one-cycle pulses.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    carry_d = carry_q;
    outp_d  = outp_q;
    ovf_d   = ovf_q;
    vld_d   = 1'b0;
    done_d  = 1'b0;

    if (clear) begin
      state_d = IDLE;
      cnt_d   = '0;
      carry_d = '0;
    end else if (in_valid) begin
      outp_d = sum_bits;
      vld_d  = 1'b1;
      unique case (state_q)
        IDLE, RUN: begin
          // With WORD_W==1 the counter sits at LAST_IDX while IDLE, so bit 0
          // completes the word and the FSM never enters RUN.
          if (last_bit) begin
            state_d = IDLE;
            cnt_d   = '0;
            carry_d = '0;
            ovf_d   = ovf_word;
            done_d  = 1'b1;
          end else begin
            state_d = RUN;
            cnt_d   = cnt_q + CNT_W'(1);
            carry_d = carry_out;
          end
        end
        default: begin
          state_d = IDLE;
          cnt_d   = '0;
          carry_d = '0;
        end
      endcase
    end
  end

  // State and output registers with asynchronous active-low reset.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      carry_q <= '0;
      outp_q  <= '0;
      ovf_q   <= '0;
      vld_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      carry_q <= carry_d;
      outp_q  <= outp_d;
      ovf_q   <= ovf_d;
      vld_q   <= vld_d;
      done_q  <= done_d;
    end
  end

  assign outp       = outp_q;
  assign outp_valid = vld_q;
  assign word_done  = done_q;
  assign overflw    = ovf_q;
  assign bit_idx    = cnt_q;

endmodule

// File: tb/tb_serial_add_ovf_nch.sv
// Directed bench for serial_add_ovf_nch: 8-bit unsigned and signed instances
// sharing stimulus, plus a separately driven WORD_W=1 instance.
module tb_serial_add_ovf_nch;

  logic       clock;
  logic       reset_n;
  logic       clear;
  logic       in_valid;
  logic [1:0] line_a;
  logic [1:0] line_b;

  logic [1:0] outp, outp_s;
  logic       outp_valid, outp_valid_s;
  logic       word_done, word_done_s;
  logic [1:0] overflw, overflw_s;
  logic [2:0] bit_idx, bit_idx_s;

  logic       clear1;
  logic       in_valid1;
  logic [1:0] line_a1;
  logic [1:0] line_b1;
  logic [1:0] outp1;
  logic       outp_valid1;
  logic       word_done1;
  logic [1:0] overflw1;
  logic [0:0] bit_idx1;

  int unsigned n_vec;
  int unsigned n_err;

  serial_add_ovf_nch #(.NCH(2), .WORD_W(8), .SIGNED(0)) u_dut (
    .clock(clock), .reset_n(reset_n), .clear(clear), .in_valid(in_valid),
    .line_a(line_a), .line_b(line_b), .outp(outp), .outp_valid(outp_valid),
    .word_done(word_done), .overflw(overflw), .bit_idx(bit_idx)
  );

  serial_add_ovf_nch #(.NCH(2), .WORD_W(8), .SIGNED(1)) u_dut_s (
    .clock(clock), .reset_n(reset_n), .clear(clear), .in_valid(in_valid),
    .line_a(line_a), .line_b(line_b), .outp(outp_s), .outp_valid(outp_valid_s),
    .word_done(word_done_s), .overflw(overflw_s), .bit_idx(bit_idx_s)
  );

  serial_add_ovf_nch #(.NCH(2), .WORD_W(1), .SIGNED(0)) u_dut_w1 (
    .clock(clock), .reset_n(reset_n), .clear(clear1), .in_valid(in_valid1),
    .line_a(line_a1), .line_b(line_b1), .outp(outp1), .outp_valid(outp_valid1),
    .word_done(word_done1), .overflw(overflw1), .bit_idx(bit_idx1)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    if ({outp, outp_valid, word_done, overflw, bit_idx} !== 9'd0) begin
      n_err++; $display("FAIL reset_u8 got %b want 0", {outp, outp_valid, word_done, overflw, bit_idx});
    end
    n_vec++;
    if ({outp_s, outp_valid_s, word_done_s, overflw_s, bit_idx_s} !== 9'd0) begin
      n_err++; $display("FAIL reset_s8 got %b want 0", {outp_s, outp_valid_s, word_done_s, overflw_s, bit_idx_s});
    end
    n_vec++;
    if ({outp1, outp_valid1, word_done1, overflw1, bit_idx1} !== 7'd0) begin
      n_err++; $display("FAIL reset_w1 got %b want 0", {outp1, outp_valid1, word_done1, overflw1, bit_idx1});
    end
    n_vec++;
    reset_n = 1'b1;
    tick();
    if ({outp, outp_valid, word_done, overflw, bit_idx} !== 9'd0) begin
      n_err++; $display("FAIL reset_idle got %b want 0", {outp, outp_valid, word_done, overflw, bit_idx});
    end
    n_vec++;
  endtask

  // lane0 0x7F+0x01 -> 0x80, lane1 0xFF+0x01 -> 0x00
  task automatic test_add();
    logic [7:0] a0, b0, a1, b1, s0, s1;
    a0 = 8'h7F; b0 = 8'h01; a1 = 8'hFF; b1 = 8'h01; s0 = 8'h80; s1 = 8'h00;
    for (int k = 0; k < 8; k++) begin
      in_valid = 1'b1;
      line_a = {a1[k], a0[k]};
      line_b = {b1[k], b0[k]};
      tick();
      if (outp_valid !== 1'b1) begin
        n_err++; $display("FAIL add_valid bit%0d got %b want 1", k, outp_valid);
      end
      n_vec++;
      if (outp !== {s1[k], s0[k]} || outp_s !== {s1[k], s0[k]}) begin
        n_err++; $display("FAIL add_sum bit%0d got %b/%b want %b", k, outp, outp_s, {s1[k], s0[k]});
      end
      n_vec++;
      if (word_done !== (k == 7)) begin
        n_err++; $display("FAIL add_done bit%0d got %b want %b", k, word_done, (k == 7));
      end
      n_vec++;
      if (bit_idx !== 3'((k + 1) % 8)) begin
        n_err++; $display("FAIL add_idx bit%0d got %0d want %0d", k, bit_idx, (k + 1) % 8);
      end
      n_vec++;
    end
    if (overflw !== 2'b10) begin
      n_err++; $display("FAIL add_ovf_unsigned got %b want 10", overflw);
    end
    n_vec++;
    if (overflw_s !== 2'b01) begin
      n_err++; $display("FAIL add_ovf_signed got %b want 01", overflw_s);
    end
    n_vec++;
    in_valid = 1'b0;
    line_a = 2'b11; line_b = 2'b11;
    tick();
    if (outp_valid !== 1'b0 || word_done !== 1'b0 || overflw !== 2'b10 || outp !== 2'b01) begin
      n_err++; $display("FAIL add_idle got v=%b d=%b o=%b s=%b want v=0 d=0 o=10 s=01",
                        outp_valid, word_done, overflw, outp);
    end
    n_vec++;
  endtask

  // partial word 0x0F+0x0F on lane0, clear at bit_idx=3, then 0xFF+0xFF
  task automatic test_clear();
    logic [7:0] pa, fa, fs;
    pa = 8'h0F; fa = 8'hFF; fs = 8'hFE;
    for (int k = 0; k < 3; k++) begin
      in_valid = 1'b1;
      line_a = {1'b0, pa[k]};
      line_b = {1'b0, pa[k]};
      tick();
    end
    if (bit_idx !== 3'd3 || outp !== 2'b01) begin
      n_err++; $display("FAIL clear_pre got idx=%0d s=%b want idx=3 s=01", bit_idx, outp);
    end
    n_vec++;
    clear = 1'b1; in_valid = 1'b1; line_a = 2'b11; line_b = 2'b11;
    tick();
    clear = 1'b0;
    if (outp_valid !== 1'b0 || word_done !== 1'b0 || bit_idx !== 3'd0) begin
      n_err++; $display("FAIL clear_ctl got v=%b d=%b idx=%0d want v=0 d=0 idx=0",
                        outp_valid, word_done, bit_idx);
    end
    n_vec++;
    if (outp !== 2'b01 || overflw !== 2'b10) begin
      n_err++; $display("FAIL clear_hold got s=%b o=%b want s=01 o=10", outp, overflw);
    end
    n_vec++;
    for (int k = 0; k < 8; k++) begin
      in_valid = 1'b1;
      line_a = {1'b0, fa[k]};
      line_b = {1'b0, fa[k]};
      tick();
      if (outp_valid !== 1'b1 || outp !== {1'b0, fs[k]} || word_done !== (k == 7)) begin
        n_err++; $display("FAIL clear_word bit%0d got v=%b s=%b d=%b want v=1 s=%b d=%b",
                          k, outp_valid, outp, word_done, {1'b0, fs[k]}, (k == 7));
      end
      n_vec++;
    end
    in_valid = 1'b0;
    if (overflw !== 2'b01 || overflw_s !== 2'b00 || bit_idx !== 3'd0) begin
      n_err++; $display("FAIL clear_end got o=%b os=%b idx=%0d want o=01 os=00 idx=0",
                        overflw, overflw_s, bit_idx);
    end
    n_vec++;
  endtask

  // lane0 0x55+0x2A with 3-cycle stalls after bits 2 and 5
  task automatic test_stall();
    logic [7:0] a0, b0, acc;
    int unsigned pulses, dones;
    a0 = 8'h55; b0 = 8'h2A; acc = '0; pulses = 0; dones = 0;
    for (int k = 0; k < 8; k++) begin
      in_valid = 1'b1;
      line_a = {1'b0, a0[k]};
      line_b = {1'b0, b0[k]};
      tick();
      if (outp_valid) begin
        pulses++;
        acc[k] = outp[0];
      end
      if (word_done) dones++;
      if (k == 2 || k == 5) begin
        for (int s = 0; s < 3; s++) begin
          in_valid = 1'b0;
          line_a = 2'b11; line_b = 2'b11;
          tick();
          if (outp_valid) pulses++;
          if (word_done) dones++;
          if (bit_idx !== 3'(k + 1) || outp !== 2'b01) begin
            n_err++; $display("FAIL stall_hold k%0d s%0d got idx=%0d s=%b want idx=%0d s=01",
                              k, s, bit_idx, outp, k + 1);
          end
          n_vec++;
        end
      end
    end
    in_valid = 1'b0;
    if (pulses != 8 || dones != 1) begin
      n_err++; $display("FAIL stall_pulses got v=%0d d=%0d want v=8 d=1", pulses, dones);
    end
    n_vec++;
    if (acc !== 8'h7F) begin
      n_err++; $display("FAIL stall_sum got %h want 7f", acc);
    end
    n_vec++;
    if (overflw !== 2'b00) begin
      n_err++; $display("FAIL stall_ovf got %b want 00", overflw);
    end
    n_vec++;
  endtask

  // two words streamed without a gap
  task automatic test_back_to_back();
    logic [7:0] a0 [2], b0 [2], a1 [2], b1 [2], s0 [2], s1 [2];
    logic [1:0] ov [2], ovs [2];
    a0[0] = 8'h80; b0[0] = 8'h80; a1[0] = 8'h12; b1[0] = 8'h34;
    s0[0] = 8'h00; s1[0] = 8'h46; ov[0] = 2'b01; ovs[0] = 2'b01;
    a0[1] = 8'h01; b0[1] = 8'h02; a1[1] = 8'hFF; b1[1] = 8'hFF;
    s0[1] = 8'h03; s1[1] = 8'hFE; ov[1] = 2'b10; ovs[1] = 2'b00;
    for (int w = 0; w < 2; w++) begin
      for (int k = 0; k < 8; k++) begin
        in_valid = 1'b1;
        line_a = {a1[w][k], a0[w][k]};
        line_b = {b1[w][k], b0[w][k]};
        tick();
        if (outp_valid !== 1'b1 || outp !== {s1[w][k], s0[w][k]} || word_done !== (k == 7)) begin
          n_err++; $display("FAIL b2b w%0d bit%0d got v=%b s=%b d=%b want v=1 s=%b d=%b",
                            w, k, outp_valid, outp, word_done, {s1[w][k], s0[w][k]}, (k == 7));
        end
        n_vec++;
      end
      if (overflw !== ov[w] || overflw_s !== ovs[w]) begin
        n_err++; $display("FAIL b2b_ovf w%0d got %b/%b want %b/%b", w, overflw, overflw_s, ov[w], ovs[w]);
      end
      n_vec++;
    end
    in_valid = 1'b0;
  endtask

  // async reset at bit_idx=5, then 0x01+0x01 on both lanes
  task automatic test_reset_midword();
    logic [7:0] one, two;
    int unsigned dones;
    one = 8'h01; two = 8'h02; dones = 0;
    for (int k = 0; k < 5; k++) begin
      in_valid = 1'b1; line_a = 2'b11; line_b = 2'b11;
      tick();
      if (word_done) dones++;
    end
    if (bit_idx !== 3'd5 || outp_valid !== 1'b1) begin
      n_err++; $display("FAIL rstmid_pre got idx=%0d v=%b want idx=5 v=1", bit_idx, outp_valid);
    end
    n_vec++;
    #2 reset_n = 1'b0;
    #1;
    if ({outp, outp_valid, word_done, overflw, bit_idx} !== 9'd0) begin
      n_err++; $display("FAIL rstmid_async got %b want 0", {outp, outp_valid, word_done, overflw, bit_idx});
    end
    n_vec++;
    tick();
    reset_n = 1'b1;
    for (int k = 0; k < 8; k++) begin
      in_valid = 1'b1;
      line_a = {one[k], one[k]};
      line_b = {one[k], one[k]};
      tick();
      if (word_done) dones++;
      if (outp !== {two[k], two[k]} || bit_idx !== 3'((k + 1) % 8)) begin
        n_err++; $display("FAIL rstmid_word bit%0d got s=%b idx=%0d want s=%b idx=%0d",
                          k, outp, bit_idx, {two[k], two[k]}, (k + 1) % 8);
      end
      n_vec++;
    end
    in_valid = 1'b0;
    if (dones != 1 || word_done !== 1'b1 || overflw !== 2'b00) begin
      n_err++; $display("FAIL rstmid_end got dones=%0d d=%b o=%b want dones=1 d=1 o=00",
                        dones, word_done, overflw);
    end
    n_vec++;
  endtask

  // WORD_W=1: every accepted bit is a full word
  task automatic test_word1();
    in_valid1 = 1'b1; line_a1 = 2'b11; line_b1 = 2'b01;
    tick();
    if (outp1 !== 2'b10 || outp_valid1 !== 1'b1 || word_done1 !== 1'b1 ||
        overflw1 !== 2'b01 || bit_idx1 !== 1'b0) begin
      n_err++; $display("FAIL w1_a got s=%b v=%b d=%b o=%b i=%b want s=10 v=1 d=1 o=01 i=0",
                        outp1, outp_valid1, word_done1, overflw1, bit_idx1);
    end
    n_vec++;
    line_a1 = 2'b11; line_b1 = 2'b10;
    tick();
    if (outp1 !== 2'b01 || word_done1 !== 1'b1 || overflw1 !== 2'b10) begin
      n_err++; $display("FAIL w1_b got s=%b d=%b o=%b want s=01 d=1 o=10", outp1, word_done1, overflw1);
    end
    n_vec++;
    in_valid1 = 1'b0; line_a1 = 2'b11; line_b1 = 2'b11;
    tick();
    if (outp_valid1 !== 1'b0 || word_done1 !== 1'b0 || overflw1 !== 2'b10 || outp1 !== 2'b01) begin
      n_err++; $display("FAIL w1_idle got v=%b d=%b o=%b s=%b want v=0 d=0 o=10 s=01",
                        outp_valid1, word_done1, overflw1, outp1);
    end
    n_vec++;
  endtask

  initial begin
    n_vec = 0; n_err = 0;
    reset_n = 1'b0; clear = 1'b0; in_valid = 1'b0; line_a = '0; line_b = '0;
    clear1 = 1'b0; in_valid1 = 1'b0; line_a1 = '0; line_b1 = '0;
    repeat (2) tick();
    test_reset();
    test_add();
    test_clear();
    test_stall();
    test_back_to_back();
    test_reset_midword();
    test_word1();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
